// File: rtl/core_pipe_pkg.sv
// Shared definitions for the ctriscv5 pipeline stage registers.
// Occupancy encodings and default widths used by stages to size their payloads.
package core_pipe_pkg;

  localparam logic [1:0] OCC_EMPTY = 2'd0;
  localparam logic [1:0] OCC_ONE   = 2'd1;
  localparam logic [1:0] OCC_TWO   = 2'd2;

  localparam int unsigned XLEN      = 32;
  localparam int unsigned CSR_IDX_W = 12;

endpackage

// File: rtl/pipe_slot.sv
// One pipeline slot: valid flag, payload and sideband with load / invalidate / hold control.
// Priority: cpurst > ld > inv > hold.
module pipe_slot #(
  parameter int unsigned DATA_W   = 64,
  parameter int unsigned KEEP_W   = 32,
  parameter int unsigned CLR_DATA = 1
) (
  input  logic              clk,
  input  logic              cpurst,
  input  logic              ld,
  input  logic              inv,
  input  logic              keep_ld,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  input  logic [KEEP_W-1:0] in_keep,
  output logic              valid,
  output logic [DATA_W-1:0] data,
  output logic [KEEP_W-1:0] keep
);

  logic              valid_q;
  logic [DATA_W-1:0] data_q;
  logic [KEEP_W-1:0] keep_q;

  always_ff @(posedge clk) begin
    if (cpurst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      keep_q  <= '0;
    end else if (ld) begin
      valid_q <= in_valid;
      data_q  <= ((CLR_DATA != 0) && !in_valid) ? '0 : in_data;
      keep_q  <= in_keep;
    end else if (inv) begin
      valid_q <= 1'b0;
      if (CLR_DATA != 0) data_q <= '0;
      if (keep_ld) keep_q <= in_keep;
    end
  end

  assign valid = valid_q;
  assign data  = data_q;
  assign keep  = keep_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Generic pipeline boundary register with valid/ready, bubble, flush, optional skid slot
// and a saturating downstream-stall counter.
module pipe_stage_reg
  import core_pipe_pkg::*;
#(
  parameter int unsigned DATA_W   = 64,
  parameter int unsigned KEEP_W   = 32,
  parameter int unsigned SKID     = 0,
  parameter int unsigned CLR_DATA = 1,
  parameter int unsigned CNT_W    = 16
) (
  input  logic              clk,
  input  logic              cpurst,
  input  logic              up_valid,
  output logic              up_ready,
  input  logic [DATA_W-1:0] up_data,
  input  logic [KEEP_W-1:0] up_keep,
  output logic              dn_valid,
  input  logic              dn_ready,
  output logic [DATA_W-1:0] dn_data,
  output logic [KEEP_W-1:0] dn_keep,
  input  logic              bubble,
  input  logic              flush,
  output logic [1:0]        occ,
  output logic [CNT_W-1:0]  stall_cnt,
  input  logic              stall_cnt_clr
);

  logic              adv;
  logic              xfer;
  logic              main_ld;
  logic              main_inv;
  logic              main_keep_ld;
  logic              main_from_skid;
  logic              main_in_valid;
  logic [DATA_W-1:0] main_in_data;
  logic [KEEP_W-1:0] main_in_keep;
  logic              skid_ld;
  logic              skid_inv;
  logic              skid_valid;
  logic [DATA_W-1:0] skid_data;
  logic [KEEP_W-1:0] skid_keep;
  logic [CNT_W-1:0]  stall_cnt_q;

  assign adv  = !dn_valid || dn_ready;
  assign xfer = up_valid && up_ready;

  // With a skid slot, up_ready derives from a flop only, never from dn_ready.
  if (SKID != 0) begin : g_rdy_skid
    assign up_ready = !skid_valid && !bubble && !cpurst;
  end else begin : g_rdy_direct
    assign up_ready = adv && !bubble && !cpurst;
  end

  always_comb begin
    main_ld        = 1'b0;
    main_inv       = 1'b0;
    main_keep_ld   = 1'b0;
    main_from_skid = 1'b0;
    skid_ld        = 1'b0;
    skid_inv       = 1'b0;
    if (flush) begin
      main_inv     = 1'b1;
      main_keep_ld = adv;
      skid_inv     = 1'b1;
    end else if ((SKID != 0) && skid_valid) begin
      // A held skid entry drains ahead of any bubble.
      if (dn_ready) begin
        main_ld        = 1'b1;
        main_from_skid = 1'b1;
        skid_inv       = 1'b1;
      end
    end else if (bubble) begin
      if (adv) begin
        main_inv     = 1'b1;
        main_keep_ld = 1'b1;
      end
    end else if (SKID == 0) begin
      main_ld = adv;
    end else begin
      if (xfer && adv) begin
        main_ld = 1'b1;
      end else if (xfer) begin
        skid_ld = 1'b1;
      end else if (adv) begin
        main_inv = 1'b1;
      end
    end
  end

  assign main_in_valid = main_from_skid ? skid_valid : up_valid;
  assign main_in_data  = main_from_skid ? skid_data  : up_data;
  assign main_in_keep  = main_from_skid ? skid_keep  : up_keep;

  pipe_slot #(
    .DATA_W   (DATA_W),
    .KEEP_W   (KEEP_W),
    .CLR_DATA (CLR_DATA)
  ) u_main (
    .clk      (clk),
    .cpurst   (cpurst),
    .ld       (main_ld),
    .inv      (main_inv),
    .keep_ld  (main_keep_ld),
    .in_valid (main_in_valid),
    .in_data  (main_in_data),
    .in_keep  (main_in_keep),
    .valid    (dn_valid),
    .data     (dn_data),
    .keep     (dn_keep)
  );

  if (SKID != 0) begin : g_skid
    pipe_slot #(
      .DATA_W   (DATA_W),
      .KEEP_W   (KEEP_W),
      .CLR_DATA (CLR_DATA)
    ) u_skid (
      .clk      (clk),
      .cpurst   (cpurst),
      .ld       (skid_ld),
      .inv      (skid_inv),
      .keep_ld  (1'b0),
      .in_valid (up_valid),
      .in_data  (up_data),
      .in_keep  (up_keep),
      .valid    (skid_valid),
      .data     (skid_data),
      .keep     (skid_keep)
    );
  end else begin : g_no_skid
    logic unused_skid_ctrl;
    assign unused_skid_ctrl = skid_ld | skid_inv;
    assign skid_valid = 1'b0;
    assign skid_data  = '0;
    assign skid_keep  = '0;
  end

  always_comb begin
    occ = OCC_EMPTY;
    if (dn_valid && skid_valid) begin
      occ = OCC_TWO;
    end else if (dn_valid || skid_valid) begin
      occ = OCC_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (cpurst || stall_cnt_clr) begin
      stall_cnt_q <= '0;
    end else if (dn_valid && !dn_ready && (stall_cnt_q != '1)) begin
      stall_cnt_q <= stall_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed self-checking bench for pipe_stage_reg: SKID=0, SKID=1 and a narrow-counter variant
// all driven from one shared stimulus stream.
module tb_pipe_stage_reg;

  localparam int unsigned DW = 16;
  localparam int unsigned KW = 16;

  logic          clk = 1'b0;
  logic          cpurst;
  logic          up_valid;
  logic [DW-1:0] up_data;
  logic [KW-1:0] up_keep;
  logic          dn_ready;
  logic          bubble;
  logic          flush;
  logic          stall_cnt_clr;

  logic          up_ready0, up_ready1, up_ready2;
  logic          dn_valid0, dn_valid1, dn_valid2;
  logic [DW-1:0] dn_data0, dn_data1, dn_data2;
  logic [KW-1:0] dn_keep0, dn_keep1, dn_keep2;
  logic [1:0]    occ0, occ1, occ2;
  logic [15:0]   stall_cnt0, stall_cnt1;
  logic [3:0]    stall_cnt2;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  pipe_stage_reg #(.DATA_W(DW), .KEEP_W(KW), .SKID(0), .CLR_DATA(1), .CNT_W(16)) u_dut0 (
    .clk (clk), .cpurst (cpurst), .up_valid (up_valid), .up_ready (up_ready0),
    .up_data (up_data), .up_keep (up_keep), .dn_valid (dn_valid0), .dn_ready (dn_ready),
    .dn_data (dn_data0), .dn_keep (dn_keep0), .bubble (bubble), .flush (flush),
    .occ (occ0), .stall_cnt (stall_cnt0), .stall_cnt_clr (stall_cnt_clr)
  );

  pipe_stage_reg #(.DATA_W(DW), .KEEP_W(KW), .SKID(1), .CLR_DATA(1), .CNT_W(16)) u_dut1 (
    .clk (clk), .cpurst (cpurst), .up_valid (up_valid), .up_ready (up_ready1),
    .up_data (up_data), .up_keep (up_keep), .dn_valid (dn_valid1), .dn_ready (dn_ready),
    .dn_data (dn_data1), .dn_keep (dn_keep1), .bubble (bubble), .flush (flush),
    .occ (occ1), .stall_cnt (stall_cnt1), .stall_cnt_clr (stall_cnt_clr)
  );

  pipe_stage_reg #(.DATA_W(DW), .KEEP_W(KW), .SKID(0), .CLR_DATA(1), .CNT_W(4)) u_dut2 (
    .clk (clk), .cpurst (cpurst), .up_valid (up_valid), .up_ready (up_ready2),
    .up_data (up_data), .up_keep (up_keep), .dn_valid (dn_valid2), .dn_ready (dn_ready),
    .dn_data (dn_data2), .dn_keep (dn_keep2), .bubble (bubble), .flush (flush),
    .occ (occ2), .stall_cnt (stall_cnt2), .stall_cnt_clr (stall_cnt_clr)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    up_valid      = 1'b0;
    up_data       = '0;
    up_keep       = '0;
    dn_ready      = 1'b0;
    bubble        = 1'b0;
    flush         = 1'b0;
    stall_cnt_clr = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    cpurst = 1'b1;
    tick();
    cpurst = 1'b0;
  endtask

  initial begin
    idle_inputs();
    // Reset flow: item presented during reset must not be captured.
    cpurst   = 1'b1;
    up_valid = 1'b1;
    up_data  = 16'h00A5;
    #1;
    check_eq("rst_up_ready0", {31'd0, up_ready0}, 32'd0);
    check_eq("rst_up_ready1", {31'd0, up_ready1}, 32'd0);
    tick();
    tick();
    check_eq("rst_dn_valid", {31'd0, dn_valid0}, 32'd0);
    check_eq("rst_dn_data", {16'd0, dn_data0}, 32'd0);
    check_eq("rst_dn_keep", {16'd0, dn_keep0}, 32'd0);
    check_eq("rst_occ0", {30'd0, occ0}, 32'd0);
    check_eq("rst_occ1", {30'd0, occ1}, 32'd0);
    check_eq("rst_stall_cnt", {16'd0, stall_cnt0}, 32'd0);
    cpurst   = 1'b0;
    dn_ready = 1'b1;
    #1;
    check_eq("post_rst_up_ready0", {31'd0, up_ready0}, 32'd1);
    tick();
    check_eq("post_rst_data0", {16'd0, dn_data0}, 32'h00A5);
    check_eq("post_rst_valid0", {31'd0, dn_valid0}, 32'd1);
    check_eq("post_rst_data1", {16'd0, dn_data1}, 32'h00A5);

    // Back-to-back streaming on SKID=0.
    for (int i = 1; i <= 8; i++) begin
      up_valid = 1'b1;
      up_data  = 16'(i);
      tick();
      check_eq($sformatf("stream_data_%0d", i), {16'd0, dn_data0}, 32'(i));
      check_eq($sformatf("stream_valid_%0d", i), {31'd0, dn_valid0}, 32'd1);
    end
    up_valid = 1'b0;
    tick();
    check_eq("stream_end_valid", {31'd0, dn_valid0}, 32'd0);
    check_eq("stream_end_data", {16'd0, dn_data0}, 32'd0);

    // Stall and skid on SKID=1.
    do_reset();
    dn_ready = 1'b1;
    up_valid = 1'b1;
    up_data  = 16'h0011;
    tick();
    check_eq("skid_main_11", {16'd0, dn_data1}, 32'h0011);
    dn_ready = 1'b0;
    up_data  = 16'h0022;
    #1;
    check_eq("skid_rdy_empty", {31'd0, up_ready1}, 32'd1);
    tick();
    up_data = 16'h0033;
    #1;
    check_eq("skid_occ2", {30'd0, occ1}, 32'd2);
    check_eq("skid_rdy_full", {31'd0, up_ready1}, 32'd0);
    check_eq("skid_hold_11", {16'd0, dn_data1}, 32'h0011);
    tick();
    check_eq("skid_still_11", {16'd0, dn_data1}, 32'h0011);
    up_valid = 1'b0;
    dn_ready = 1'b1;
    tick();
    check_eq("skid_out_22", {16'd0, dn_data1}, 32'h0022);
    check_eq("skid_occ1", {30'd0, occ1}, 32'd1);
    check_eq("skid_rdy_back", {31'd0, up_ready1}, 32'd1);
    tick();
    check_eq("skid_drained_valid", {31'd0, dn_valid1}, 32'd0);
    check_eq("skid_drained_occ", {30'd0, occ1}, 32'd0);

    // Bubble on SKID=0.
    do_reset();
    dn_ready = 1'b1;
    up_valid = 1'b1;
    up_data  = 16'h0055;
    up_keep  = 16'h00AA;
    tick();
    up_data = 16'h0066;
    up_keep = 16'h0100;
    bubble  = 1'b1;
    #1;
    check_eq("bub_up_ready", {31'd0, up_ready0}, 32'd0);
    tick();
    check_eq("bub_valid", {31'd0, dn_valid0}, 32'd0);
    check_eq("bub_data", {16'd0, dn_data0}, 32'd0);
    check_eq("bub_keep", {16'd0, dn_keep0}, 32'h0100);
    bubble  = 1'b0;
    up_data = 16'h0077;
    up_keep = 16'h0200;
    tick();
    check_eq("bub_reload", {16'd0, dn_data0}, 32'h0077);
    dn_ready = 1'b0;
    bubble   = 1'b1;
    up_data  = 16'h0088;
    up_keep  = 16'h0300;
    tick();
    check_eq("bub_hold_valid", {31'd0, dn_valid0}, 32'd1);
    check_eq("bub_hold_data", {16'd0, dn_data0}, 32'h0077);
    check_eq("bub_hold_keep", {16'd0, dn_keep0}, 32'h0200);

    // Flush and bubble together with the skid slot full.
    do_reset();
    dn_ready = 1'b1;
    up_valid = 1'b1;
    up_data  = 16'h0011;
    tick();
    dn_ready = 1'b0;
    up_data  = 16'h0022;
    tick();
    check_eq("fl_occ_full", {30'd0, occ1}, 32'd2);
    up_valid = 1'b0;
    flush    = 1'b1;
    bubble   = 1'b1;
    tick();
    check_eq("fl_valid", {31'd0, dn_valid1}, 32'd0);
    check_eq("fl_occ", {30'd0, occ1}, 32'd0);
    flush    = 1'b0;
    bubble   = 1'b0;
    dn_ready = 1'b1;
    up_valid = 1'b1;
    up_data  = 16'h0044;
    tick();
    check_eq("fl_next_valid", {31'd0, dn_valid1}, 32'd1);
    check_eq("fl_next_data", {16'd0, dn_data1}, 32'h0044);

    // Reset with skid full drops everything.
    dn_ready = 1'b0;
    up_data  = 16'h0045;
    tick();
    check_eq("rst_mid_full", {30'd0, occ1}, 32'd2);
    do_reset();
    check_eq("rst_mid_occ", {30'd0, occ1}, 32'd0);

    // Stall counter, including saturation of the 4-bit variant.
    dn_ready = 1'b1;
    up_valid = 1'b1;
    up_data  = 16'h0099;
    tick();
    up_valid = 1'b0;
    dn_ready = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    check_eq("cnt_5_w16", {16'd0, stall_cnt0}, 32'd5);
    check_eq("cnt_5_w4", {28'd0, stall_cnt2}, 32'd5);
    for (int i = 0; i < 15; i++) tick();
    check_eq("cnt_20_w16", {16'd0, stall_cnt0}, 32'd20);
    check_eq("cnt_20_w4_sat", {28'd0, stall_cnt2}, 32'd15);
    stall_cnt_clr = 1'b1;
    tick();
    check_eq("cnt_clr_w16", {16'd0, stall_cnt0}, 32'd0);
    check_eq("cnt_clr_w4", {28'd0, stall_cnt2}, 32'd0);
    stall_cnt_clr = 1'b0;
    tick();
    check_eq("cnt_resume", {16'd0, stall_cnt0}, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
- Generic, parametrised pipeline boundary register for the ctriscv5 core. It generalises the execute→memory stage register into one block reused at IF/ID, ID/EX, EX/MEM and MEM/WB.
- Carries an opaque payload plus a "keep" sideband field. The keep field holds values such as the PC that must survive bubble insertion.
- Uses a valid/ready handshake, bubble insertion, flush, and an optional one-entry skid slot so up_ready can be registered.
- Includes a saturating downstream-stall cycle counter for performance monitoring.

Parameters:
DATA_W, 64, payload width in bits (control and data fields, packed by the instantiating stage)
KEEP_W, 32, sideband width; not zeroed on bubble or flush
SKID, 0, 0 = single register (up_ready is combinational); 1 = main plus skid register (up_ready is registered)
CLR_DATA, 1, 1 = dn_data is driven to zero whenever its slot is invalid; 0 = stale data is retained
CNT_W, 16, width of stall counter

Ports:
clk  in  1  core clock
cpurst  in  1  synchronous, active-high reset
up_valid  in  1  upstream item present
up_ready  out  1  this stage accepts the item this cycle
up_data  in  DATA_W  upstream payload
up_keep  in  KEEP_W  upstream sideband
dn_valid  out  1  registered item valid
dn_ready  in  1  downstream accepts; low = memacc-style stall
dn_data  out  DATA_W  registered payload
dn_keep  out  KEEP_W  registered sideband
bubble  in  1  insert NOP downstream and hold upstream (the exe_stall equivalent)
flush  in  1  discard all held and incoming items
occ  out  2  occupied slots: 0, 1, or 2 (2 only when SKID=1)
stall_cnt  out  CNT_W  saturating count of cycles with dn_valid && !dn_ready
stall_cnt_clr  in  1  synchronous clear of stall_cnt

Behaviour:
- Reset: all outputs and internal state are 0. This includes dn_valid, dn_data, dn_keep, occ, stall_cnt and the skid slot. up_ready is 0 during the reset cycle.
- Definitions:
  - adv = !dn_valid || dn_ready (the output register may change).
  - xfer = up_valid && up_ready.
- Priority per cycle: cpurst > flush > bubble > normal.
- flush:
  - dn_valid <= 0 and skid valid <= 0.
  - dn_data <= 0 when CLR_DATA=1.
  - dn_keep <= up_keep when adv; otherwise dn_keep is held.
  - up_ready follows the normal rule. An item transferred in the flush cycle is consumed and dropped.
- bubble:
  - When adv: dn_valid <= 0, dn_data <= 0 (CLR_DATA=1), dn_keep <= up_keep.
  - up_ready is forced to 0.
  - When !adv: bubble has no effect and the output is held.
  - With SKID=1 and a valid skid slot: the skid entry moves to main when adv, and no bubble is inserted that cycle. Bubble applies only when the skid slot is empty.
- Normal, SKID=0:
  - up_ready = adv && !bubble && !cpurst. This path is combinational.
  - On adv: dn_valid <= up_valid; dn_data <= up_data; dn_keep <= up_keep.
  - On !adv: the output is held.
  - Latency is 1 cycle. Throughput is 1 item per cycle.
- Normal, SKID=1:
  - up_ready = !skid_valid. This is registered and independent of dn_ready.
  - Skid full (skid_valid=1): when dn_ready, main <= skid and skid_valid <= 0.
  - Skid empty and xfer with adv: main <= up.
  - Skid empty and xfer with !adv: skid <= up and skid_valid <= 1.
  - Skid empty, no xfer, adv: main takes the invalid state. dn_data is zeroed per CLR_DATA. dn_keep is held.
  - Ordering is strictly FIFO. An item is never duplicated or lost except through flush.
- occ = dn_valid + skid_valid.
- stall_cnt:
  - Increments each cycle in which dn_valid && !dn_ready.
  - Saturates at all-ones and does not wrap.
  - stall_cnt_clr takes priority over increment. Reset clears it.
- Reset mid-transfer: all items are dropped and there is no residual valid.
- Simultaneous flush and bubble: flush wins.
- Simultaneous flush and skid full: both entries are dropped.

Decomposition:
- Shared package core_pipe_pkg:
  - occupancy constants OCC_EMPTY=0, OCC_ONE=1, OCC_TWO=2.
  - Default widths XLEN=32 and a CSR index width of 12, used by stages to size DATA_W.
- One natural sub-module: pipe_slot (valid + data + keep register with load, clear and hold controls).
  - Instantiated as main, and also as skid when SKID=1.
  - Counter logic stays inline.

Test Plan:
- Reset flow: cpurst=1 for 2 cycles with up_valid=1 and up_data=0xA5 → dn_valid=0, dn_data=0, dn_keep=0, occ=0, stall_cnt=0. Then cpurst=0 and dn_ready=1 → dn_data=0xA5 one cycle later.
- Back-to-back streaming: SKID=0, dn_ready=1, items 1..8 on consecutive cycles → dn_data sequence 1..8 at latency 1, with no gaps.
- Stall and skid: SKID=1, item 0x11 in main, dn_ready=0, item 0x22 sent:
  - → 0x22 captured in skid, occ=2, up_ready=0 next cycle.
  - Then dn_ready=1 → 0x11 then 0x22 out in order, and up_ready returns to 1.
- Bubble: pc=0x100 on up_keep, bubble=1 with dn_ready=1 → dn_valid=0, dn_data=0, dn_keep=0x100, up_ready=0. Repeating with dn_ready=0 and dn_valid=1 → output held unchanged.
- Flush vs bubble: flush=1 and bubble=1 together with skid full → dn_valid=0, occ=0; the next accepted item appears normally.
- Counter: 5 stall cycles → stall_cnt=5. With CNT_W=4, 20 stall cycles → 15 (saturated). stall_cnt_clr=1 during a stall cycle → 0.
